piso_tx: RTL and testbench
==========================

// Module: piso_tx
// PURPOSE
//   Parallel-in/serial-out transmitter; the stage directly upstream of the sipo shift register.
//   - Accepts a WIDTH-bit word over a valid/ready handshake.
//   - Shifts the word out one bit per clk on so, framed by so_valid, to drive the sipo si input.
//   - Supports back-to-back words with no idle gap.
// PARAMETERS
//   WIDTH      4   word width in bits, >= 2
//   MSB_FIRST  1   1: pi[WIDTH-1] is sent first; 0: pi[0] is sent first
// PORTS
//   clk         in   1      single clock; all state changes on posedge
//   rst         in   1      asynchronous, active-low reset (0 = reset)
//   pi          in   WIDTH  parallel word; sampled only on an accepted load
//   load_valid  in   1      pi holds a word to send
//   load_ready  out  1      block can accept a word this cycle
//   so          out  1      serial data, to sipo si
//   so_valid    out  1      so carries a valid bit this cycle
//   busy        out  1      shift in progress (state SHIFT)
//   done        out  1      1-cycle pulse on the cycle the last bit is on so
// BEHAVIOUR
//   Reset (rst=0, asynchronous): state=IDLE; shreg=0; cnt=0; so=0; so_valid=0; busy=0; done=0.
//     load_ready=1 as soon as reset is applied.
//   FSM states:
//     IDLE  -> SHIFT  on accept.
//     SHIFT -> SHIFT  while cnt < WIDTH-1, or on the last bit when a new word is accepted.
//     SHIFT -> IDLE   on the last bit (cnt == WIDTH-1) with no accept.
//   Accept = load_valid & load_ready at a posedge.
//   load_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1). Combinational, no dependence on load_valid.
//   Latency: word accepted at edge k -> its first bit is on so after edge k.
//     Bits occupy cycles k+1 .. k+WIDTH.
//     so_valid=1 for exactly WIDTH cycles per word.
//   Registered outputs: so is the shreg output bit (MSB when MSB_FIRST=1, LSB otherwise).
//   Each posedge in SHIFT that does not accept a new word:
//     - shreg shifts toward the output end; the vacated bit fills with 0.
//     - cnt increments.
//   cnt counts 0..WIDTH-1.
//     - It wraps to 0 on accept.
//     - It holds at 0 in IDLE.
//     - Its width is $clog2(WIDTH).
//   done = so_valid & (cnt==WIDTH-1). Not asserted in IDLE.
//   Boundary cases:
//     - Back-to-back: an accept on the last-bit cycle reloads shreg and sets cnt=0.
//       Next cycle so = first bit of the new word; so_valid stays 1 with no gap.
//     - load_valid while mid-word: ignored (load_ready=0); pi is not sampled.
//     - IDLE: so=0, so_valid=0; pi changes have no effect.
//     - Reset mid-word: the word is dropped immediately; no done pulse is issued.
//   After reset release, operation resumes from IDLE on the next posedge.
// STRUCTURE
//   Shared package/header (counters/registers defines):
//     - localparam state codes ST_IDLE=1'b0, ST_SHIFT=1'b1
//     - localparam default widths shared with sipo (WIDTH=4)
//   Sub-module: mod_n_counter (modulus WIDTH, async active-low rst, en, clr, count, terminal).
//     - Used for cnt.
//     - terminal drives load_ready/done.
//   Top level contains: FSM register, shreg, output mux.
// TESTING
//   1. Reset: rst=0 at t=0, released at t=3 -> so=0, so_valid=0, busy=0, done=0, load_ready=1.
//   2. Single word, MSB_FIRST=1: pi=4'b1011 with 1-cycle load_valid.
//      - so = 1,0,1,1 on 4 consecutive cycles; so_valid=1 for 4 cycles; done high on the 4th.
//      - Downstream sipo po=4'b1011 after the 4th shift.
//   3. Back-to-back: 4'b1100 then 4'b0011, load_valid held high.
//      - so = 1,1,0,0,0,0,1,1 with so_valid continuous for 8 cycles.
//      - 2 done pulses.
//   4. Ignore mid-word: accept 4'b1111, then drive pi=4'b0000 with load_valid=1 during bits 1-2.
//      - so stays 1,1,1,1; load_ready=0 on those cycles.
//   5. Reset mid-word: assert rst=0 after bit 2 of 4'b1010.
//      - so=0 and so_valid=0 immediately (asynchronous); no done pulse.
//      - After release, 4'b0110 is sent correctly.
//   6. MSB_FIRST=0, WIDTH=8: pi=8'hA5 -> so = 1,0,1,0,0,1,0,1 (LSB first); done on the 8th bit.

Source files
------------

// File: rtl/piso_tx_pkg.sv
// Shared constants for the piso_tx transmitter and its neighbours on the
// serial link (the downstream sipo uses the same default word width).
package piso_tx_pkg;

    // FSM state codes, kept as plain 1-bit constants so older code that
    // compares against raw bit patterns keeps working.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Default word width shared by the transmitter and the sipo receiver.
    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_tx_counter.sv
// Modulus-MOD up counter with clear and enable. terminal flags the last
// count value so the parent can spot the final bit of a word without its
// own comparator.
module mod_n_counter
    import piso_tx_pkg::*;
#(
    parameter int MOD = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    output logic [$clog2(MOD)-1:0] count,
    output logic                   terminal
);

    localparam int CW = $clog2(MOD);
    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    // Count 0..MOD-1 and wrap; clear takes priority over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter. A word accepted over load_valid /
// load_ready is shifted out one bit per clock on so, framed by so_valid.
// Handshake: a word transfers on any posedge where load_valid and
// load_ready are both 1; load_ready depends only on internal state, and pi
// is sampled only on that transferring edge. Accepting on the last-bit
// cycle lets words run back-to-back with no gap on so_valid.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             accept;
    logic             shifting;

    assign shifting   = (state == ST_SHIFT);
    assign load_ready = (state == ST_IDLE) | (shifting & last_bit);
    assign accept     = load_valid & load_ready;

    // Bit counter: runs while shifting, restarts at 0 on every accepted
    // word and wraps to 0 after the last bit so it rests at 0 in IDLE.
    mod_n_counter #(
        .MOD (WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (shifting),
        .clr      (accept),
        .count    (cnt),
        .terminal (last_bit)
    );

    // FSM: leave IDLE on accept; return to IDLE after the last bit unless
    // a new word is taken on that same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (accept) state <= ST_SHIFT;
                ST_SHIFT: if (last_bit && !accept) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Shift register: load on accept, otherwise shift toward the output
    // end while shifting, filling with 0 so it is empty once back in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= pi;
        end else if (shifting) begin
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, shreg[WIDTH-1:1]};
        end
    end

    assign so       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign so_valid = shifting;
    assign busy     = shifting;
    assign done     = shifting & last_bit;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: a WIDTH=4 MSB-first instance and a WIDTH=8
// LSB-first instance share the clock and reset.
module tb_piso_tx;

    logic       clk;
    logic       rst;

    logic [3:0] pi4;
    logic       lv4, lr4, so4, sv4, busy4, done4;
    logic [7:0] pi8;
    logic       lv8, lr8, so8, sv8, busy8, done8;

    int pass_count  = 0;
    int check_count = 0;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
        .clk(clk), .rst(rst), .pi(pi4), .load_valid(lv4), .load_ready(lr4),
        .so(so4), .so_valid(sv4), .busy(busy4), .done(done4)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst(rst), .pi(pi8), .load_valid(lv8), .load_ready(lr8),
        .so(so8), .so_valid(sv8), .busy(busy8), .done(done8)
    );

    // Clock: period 10, first posedge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vectors below are {so, so_valid, done, load_ready, busy}.
    task automatic test_reset();
        #1; // t=4: reset released at t=3, before any clock edge
        check_count++;
        if ({so4, sv4, done4, lr4, busy4} !== 5'b00010)
            $display("FAIL reset_w4 got=%b exp=%b", {so4, sv4, done4, lr4, busy4}, 5'b00010);
        else pass_count++;
        check_count++;
        if ({so8, sv8, done8, lr8, busy8} !== 5'b00010)
            $display("FAIL reset_w8 got=%b exp=%b", {so8, sv8, done8, lr8, busy8}, 5'b00010);
        else pass_count++;
    endtask

    task automatic test_single_word();
        logic [3:0] word;
        logic [3:0] po;
        logic [4:0] exp;
        word = 4'b1011;
        po   = 4'b0000;
        tick();
        pi4 = word; lv4 = 1'b1;
        tick();
        lv4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp = {word[3-i], 1'b1, (i == 3), (i == 3), 1'b1};
            check_count++;
            if ({so4, sv4, done4, lr4, busy4} !== exp)
                $display("FAIL single_bit%0d got=%b exp=%b", i, {so4, sv4, done4, lr4, busy4}, exp);
            else pass_count++;
            if (sv4) po = {po[2:0], so4};
            tick();
        end
        check_count++;
        if ({so4, sv4, done4, lr4, busy4} !== 5'b00010)
            $display("FAIL single_idle got=%b exp=%b", {so4, sv4, done4, lr4, busy4}, 5'b00010);
        else pass_count++;
        check_count++;
        if (po !== 4'b1011)
            $display("FAIL single_sipo_po got=%b exp=%b", po, 4'b1011);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_so;
        int         dones;
        exp_so = 8'b1100_0011; // sent left to right
        dones  = 0;
        pi4 = 4'b1100; lv4 = 1'b1;
        tick();
        pi4 = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            check_count++;
            if ({so4, sv4} !== {exp_so[7-i], 1'b1})
                $display("FAIL b2b_bit%0d got=%b exp=%b", i, {so4, sv4}, {exp_so[7-i], 1'b1});
            else pass_count++;
            if (done4) dones++;
            if (i == 4) lv4 = 1'b0;
            tick();
        end
        check_count++;
        if (dones !== 2)
            $display("FAIL b2b_done_count got=%0d exp=%0d", dones, 2);
        else pass_count++;
        check_count++;
        if (sv4 !== 1'b0)
            $display("FAIL b2b_end_valid got=%b exp=%b", sv4, 1'b0);
        else pass_count++;
    endtask

    task automatic test_ignore_midword();
        pi4 = 4'b1111; lv4 = 1'b1;
        tick();
        pi4 = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) lv4 = 1'b0;
            check_count++;
            if ({so4, sv4, lr4} !== {1'b1, 1'b1, (i == 3)})
                $display("FAIL ignore_bit%0d got=%b exp=%b", i, {so4, sv4, lr4}, {1'b1, 1'b1, (i == 3)});
            else pass_count++;
            tick();
        end
        check_count++;
        if ({so4, sv4, busy4} !== 3'b000)
            $display("FAIL ignore_idle got=%b exp=%b", {so4, sv4, busy4}, 3'b000);
        else pass_count++;
    endtask

    task automatic test_reset_midword();
        logic [3:0] word;
        int         dones;
        dones = 0;
        pi4 = 4'b1010; lv4 = 1'b1;
        tick();
        lv4 = 1'b0;
        check_count++;
        if (so4 !== 1'b1)
            $display("FAIL rstmid_bit0 got=%b exp=%b", so4, 1'b1);
        else pass_count++;
        tick();
        check_count++;
        if (so4 !== 1'b0)
            $display("FAIL rstmid_bit1 got=%b exp=%b", so4, 1'b0);
        else pass_count++;
        rst = 1'b0;
        #1;
        check_count++;
        if ({so4, sv4, done4, lr4, busy4} !== 5'b00010)
            $display("FAIL rstmid_async got=%b exp=%b", {so4, sv4, done4, lr4, busy4}, 5'b00010);
        else pass_count++;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done4 || sv4) dones++;
        end
        check_count++;
        if (dones !== 0)
            $display("FAIL rstmid_no_done got=%0d exp=%0d", dones, 0);
        else pass_count++;
        word = 4'b0110;
        pi4 = word; lv4 = 1'b1;
        tick();
        lv4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_count++;
            if ({so4, sv4, done4} !== {word[3-i], 1'b1, (i == 3)})
                $display("FAIL rstmid_resend_bit%0d got=%b exp=%b", i, {so4, sv4, done4}, {word[3-i], 1'b1, (i == 3)});
            else pass_count++;
            tick();
        end
    endtask

    task automatic test_lsb_first_w8();
        logic [7:0] exp_so;
        exp_so = 8'b1010_0101; // expected so sequence, sent left to right
        pi8 = 8'hA5; lv8 = 1'b1;
        tick();
        lv8 = 1'b0;
        pi8 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check_count++;
            if ({so8, sv8, done8} !== {exp_so[7-i], 1'b1, (i == 7)})
                $display("FAIL w8_bit%0d got=%b exp=%b", i, {so8, sv8, done8}, {exp_so[7-i], 1'b1, (i == 7)});
            else pass_count++;
            tick();
        end
        check_count++;
        if ({so8, sv8, done8, lr8, busy8} !== 5'b00010)
            $display("FAIL w8_idle got=%b exp=%b", {so8, sv8, done8, lr8, busy8}, 5'b00010);
        else pass_count++;
    endtask

    initial begin
        rst = 1'b0;
        pi4 = '0; lv4 = 1'b0;
        pi8 = '0; lv8 = 1'b0;
        #3 rst = 1'b1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_ignore_midword();
        test_reset_midword();
        test_lsb_first_w8();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
